// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake for uart_tx_fifo: byte, write request and FIFO-not-full.
interface uart_tx_fifo_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module uart_tx_fifo #(
  parameter int CLK_FEQ    = 50_000_000,
  parameter int UART_BOT   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 tx_if,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          send_end,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_CNT_MAX = CLK_FEQ / UART_BOT;
  localparam int CNT_W       = (BIT_CNT_MAX > 1) ? $clog2(BIT_CNT_MAX) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT_MAX - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  // Elaboration-time legality checks on the configuration.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..256");
  end
  if (PARITY_ODD != 1'b0 && PARITY_ODD != 1'b1) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [LVL_W-1:0]       r_level;

  logic [CNT_W-1:0]       r_baud_cnt;
  logic [2:0]             r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_tx;
  logic                   r_send_end;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
`endif

  logic                   w_wr_en;
  logic                   w_pop;
  logic                   w_not_empty;
  logic                   w_bit_end;
  logic                   w_frame_end;
  logic                   w_tx_next;
  logic [DATA_BITS-1:0]   w_head;
  logic [DATA_BITS-1:0]   w_shift_next;

  // ------------------------------------------------------------------ FIFO
  assign w_not_empty         = (r_level != '0);
  assign tx_if.data_in_ready = (r_level != LVL_FULL);
  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign w_wr_en             = tx_if.data_in_valid && tx_if.data_in_ready;
  assign w_head              = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; pointers and level alone decide which
  // entries are valid, so clearing them discards the contents and keeps the array RAM-mappable.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= tx_if.data_in[DATA_BITS-1:0];
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ------------------------------------------------------------------ FSM
  assign w_bit_end = (r_baud_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_frame_end  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_not_empty) begin
          w_pop        = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_end && r_bit_idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_end && r_bit_idx == STOP_LAST) begin
          w_frame_end = 1'b1;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (w_not_empty) begin
            w_pop        = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Byte is captured at pop time so later FIFO writes cannot touch the frame in flight.
  always_comb begin
    w_shift_next = r_shift;
    if (w_pop) begin
      w_shift_next = w_head;
    end else if (r_state == DATA && w_bit_end) begin
      w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
    end
  end

  // Line level is derived from the next state so uart_tx changes on the same edge as the state.
  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_parity;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_send_end <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_send_end <= w_frame_end;

      if (r_state == IDLE || w_bit_end) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
      end

      // Bit index counts data bits, then stop bits; it restarts on every state change.
      if (r_state == IDLE) begin
        r_bit_idx <= '0;
      end else if (w_bit_end) begin
        r_bit_idx <= (w_state_next != r_state) ? 3'd0 : r_bit_idx + 3'd1;
      end

`ifdef UART_TX_PARITY_EN
      if (w_pop) begin
        r_parity <= (^w_head) ^ PARITY_ODD;
      end
`endif
    end
  end

  assign uart_tx    = r_tx;
  assign send_end   = r_send_end;
  assign busy       = (r_state != IDLE) || w_not_empty;
  assign fifo_level = r_level;

endmodule
